lsu: RTL and testbench
======================

Name: lsu

Overview:
- Load/store unit directly downstream of the ALU.
- Consumes the ALU's effective-address result (base + offset from the adder path) and the rs2 store data.
- Runs one word-wide memory bus transaction per request: byte lanes, write strobes, load sign/zero extension.
- Holds the pipeline through o_busy, combined with the ALU busy line, until the access completes.

Parameters:
- TIMEOUT_W, 8: width of the bus-ack timeout counter; the access faults after 2^TIMEOUT_W-1 cycles without ack.

Ports:
- i_clk_n  in  1  inverted clock; all flops update on its rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  request valid this cycle
- i_load  in  1  request is a load
- i_store  in  1  request is a store; i_load && i_store together is ignored (no access)
- i_funct3  in  3  access size/sign, RV32I load/store encoding
- i_addr  in  32  effective address (ALU output)
- i_store_data  in  32  store data, unshifted, in the low bits
- o_busy  out  1  stall request to the pipeline
- o_done  out  1  one-cycle completion pulse
- o_load_data  out  32  extended load result, valid when o_done
- o_fault  out  1  one-cycle pulse on timeout, bad funct3 or misalignment (when enabled)
- o_mem_req  out  1  bus request
- o_mem_we  out  1  bus write
- o_mem_addr  out  32  word address, {i_addr[31:2],2'b00}
- o_mem_wstrb  out  4  byte write strobes
- o_mem_wdata  out  32  lane-shifted write data
- i_mem_ack  in  1  bus acknowledge, one cycle; read data valid the same cycle
- i_mem_rdata  in  32  bus read data

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; all registered outputs 0; o_load_data 0; timeout counter 0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Accepts when i_valid && (i_load ^ i_store).
  - Latches addr[1:0], funct3, direction, word address, shifted wdata and strobes.
  - Bad funct3 goes to DONE with fault and no bus activity. Loads: 011, 110, 111 are bad. Stores: any funct3 other than 000/001/010 is bad.
  - Otherwise goes to REQ.
- REQ:
  - o_mem_req=1; bus outputs held stable until ack.
  - On i_mem_ack: capture i_mem_rdata, extend, then go to DONE.
  - Counter increments each REQ cycle. At all-ones without ack: drop req, go to DONE with fault, o_load_data=0.
- DONE: o_done=1 for exactly one cycle; o_fault=1 if flagged; then IDLE. A new request can be accepted in the next cycle.
- o_busy (combinational):
  - 1 when state==REQ.
  - 1 when state==IDLE and an access is accepted.
  - 0 in DONE, so the pipeline advances on the o_done cycle.
- Minimum latency: accept cycle N, req N+1, ack N+1, done N+2.
- Store lanes:
  - SB: wdata={4{d[7:0]}}, wstrb=4'b0001<<a[1:0].
  - SH: wdata={2{d[15:0]}}, wstrb=4'b0011<<{a[1],1'b0}.
  - SW: wdata=d, wstrb=4'b1111.
- Loads: o_mem_we=0, wstrb=0. Byte/half selected by the latched a[1:0], then sign-extended (000/001) or zero-extended (100/101). LW passes through.
- An ack outside REQ is ignored.
- Reset mid-transaction: immediate return to IDLE; req drops asynchronously; no done pulse.

Optional Feature:
- LSU_MISALIGN_TRAP_EN defined:
  - Halfword with a[0]=1 or word with a[1:0]!=0 faults.
  - No bus access; IDLE goes to DONE with o_fault=1 and o_load_data=0.
- Undefined:
  - Low bits are truncated and the access proceeds: halfword uses a[1]; word ignores a[1:0].
  - o_fault is raised only by timeout or bad funct3.

Decomposition:
- Shared package/include holds:
  - funct3 constants: LB/LH/LW/LBU/LHU/SB/SH/SW.
  - FSM state encodings: IDLE=2'd0, REQ=2'd1, DONE=2'd2.
  - Default TIMEOUT_W.
- One natural sub-module, lsu_align: combinational store lane shift/strobe generation plus load extract/extend. The FSM stays in lsu.

Test Plan:
- SB addr 0x1003, data 0xA5 -> wstrb 4'b1000, wdata 0xA5A5A5A5, mem_addr 0x1000, o_done two cycles after accept with immediate ack.
- LB addr 0x2001, rdata 0x0000_8000 -> o_load_data 0xFFFF_FF80. LBU same inputs -> 0x0000_0080. LHU addr 0x2002, rdata 0xBEEF_0000 -> 0x0000_BEEF.
- LW with ack delayed 5 cycles -> o_busy high 6 cycles, req stable throughout, single o_done pulse, data 0x1234_5678 passes through.
- No ack with TIMEOUT_W=4 -> req for 15 cycles, then o_done=o_fault=1, load data 0, back to IDLE.
- LH addr 0x3001:
  - With LSU_MISALIGN_TRAP_EN -> fault, no req ever asserted.
  - Without it -> access at 0x3000 using half 0.
- i_rst_n low during REQ -> req 0 asynchronously; after release, a back-to-back SW/LW pair completes in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants, FSM encoding and helpers for the load/store unit.
//   - funct3 encodings for RV32I loads and stores
//   - FSM state type (IDLE/REQ/DONE)
//   - default bus-ack timeout counter width
//   - bus payload struct and funct3 legality / alignment helpers
package lsu_pkg;

  localparam int unsigned LSU_TIMEOUT_W = 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // Bus-side payload held stable for the whole REQ phase
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } lsu_bus_t;

  // Encodings outside the RV32I load/store set
  function automatic logic f3_bad(input logic is_load, input logic [2:0] f3);
    if (is_load)
      return !(f3 == F3_LB || f3 == F3_LH || f3 == F3_LW || f3 == F3_LBU || f3 == F3_LHU);
    return !(f3 == F3_SB || f3 == F3_SH || f3 == F3_SW);
  endfunction

  // Halfword on an odd byte, or word off a word boundary
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane handling for the load/store unit.
//   Store side: i_st_funct3/i_st_off/i_st_data -> o_wdata (lane-replicated), o_wstrb
//   Load side:  i_ld_funct3/i_ld_off/i_rdata   -> o_load_data (selected, extended)
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Store: replicate the datum across lanes, strobe only the addressed ones
  always_comb begin
    o_wdata = i_st_data;
    o_wstrb = 4'b1111;
    case (i_st_funct3)
      F3_SB: begin
        o_wdata = {4{i_st_data[7:0]}};
        o_wstrb = 4'b0001 << i_st_off;
      end
      F3_SH: begin
        o_wdata = {2{i_st_data[15:0]}};
        o_wstrb = 4'b0011 << {i_st_off[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Load: pick the addressed byte/half, then sign- or zero-extend
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_ld_off)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: ;
    endcase
    w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_ld_funct3)
      F3_LB:   o_load_data = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_load_data = {{16{w_half[15]}}, w_half};
      F3_LBU:  o_load_data = {24'd0, w_byte};
      F3_LHU:  o_load_data = {16'd0, w_half};
      default: o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit issuing one word-wide bus transaction per request.
//   Pipeline side: i_valid/i_load/i_store/i_funct3/i_addr/i_store_data in;
//                  o_busy (combinational stall), o_done, o_fault, o_load_data out.
//   Bus side:      o_mem_req/o_mem_we/o_mem_addr/o_mem_wstrb/o_mem_wdata out;
//                  i_mem_ack/i_mem_rdata in.
//   Clocked on the rising edge of i_clk_n; i_rst_n is async active-low.
//   Define LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses
//   instead of truncating the low address bits.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_W = LSU_TIMEOUT_W
) (
  input  logic        i_clk_n,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_store_data,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_load_data,
  output logic        o_fault,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  lsu_state_e           r_state;
  lsu_bus_t             r_bus;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [2:0]           r_funct3;
  logic [1:0]           r_off;

  logic                 w_accept;
  logic                 w_bad;
  logic                 w_timeout;
  logic [TIMEOUT_W-1:0] w_cnt_nxt;
  logic [31:0]          w_wdata;
  logic [3:0]           w_wstrb;
  logic [31:0]          w_ld_data;

  assign w_accept = (r_state == IDLE) && i_valid && (i_load ^ i_store);

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_bad = f3_bad(i_load, i_funct3) || misaligned(i_funct3, i_addr[1:0]);
`else
  assign w_bad = f3_bad(i_load, i_funct3);
`endif

  // Timeout fires on the REQ cycle that would bring the counter to all-ones
  assign w_cnt_nxt = r_cnt + TIMEOUT_W'(1);
  assign w_timeout = &w_cnt_nxt;

  assign o_busy = w_accept || (r_state == REQ);

  assign o_mem_we    = r_bus.we;
  assign o_mem_addr  = r_bus.addr;
  assign o_mem_wstrb = r_bus.wstrb;
  assign o_mem_wdata = r_bus.wdata;

  lsu_align u_align (
    .i_st_funct3 (i_funct3),
    .i_st_off    (i_addr[1:0]),
    .i_st_data   (i_store_data),
    .o_wdata     (w_wdata),
    .o_wstrb     (w_wstrb),
    .i_ld_funct3 (r_funct3),
    .i_ld_off    (r_off),
    .i_rdata     (i_mem_rdata),
    .o_load_data (w_ld_data)
  );

  // Access FSM with registered bus and completion outputs
  always_ff @(posedge i_clk_n or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_bus       <= '0;
      r_cnt       <= '0;
      r_funct3    <= 3'd0;
      r_off       <= 2'd0;
      o_mem_req   <= 1'b0;
      o_done      <= 1'b0;
      o_fault     <= 1'b0;
      o_load_data <= 32'd0;
    end else begin
      o_done  <= 1'b0;
      o_fault <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_funct3    <= i_funct3;
            r_off       <= i_addr[1:0];
            r_cnt       <= '0;
            o_load_data <= 32'd0;
            r_bus.we    <= i_store;
            r_bus.addr  <= {i_addr[31:2], 2'b00};
            r_bus.wstrb <= i_store ? w_wstrb : 4'b0000;
            r_bus.wdata <= i_store ? w_wdata : 32'd0;
            if (w_bad) begin
              r_state <= DONE;
              o_done  <= 1'b1;
              o_fault <= 1'b1;
            end else begin
              r_state   <= REQ;
              o_mem_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (i_mem_ack) begin
            r_state     <= DONE;
            o_mem_req   <= 1'b0;
            o_done      <= 1'b1;
            o_load_data <= r_bus.we ? 32'd0 : w_ld_data;
          end else if (w_timeout) begin
            r_state     <= DONE;
            o_mem_req   <= 1'b0;
            o_done      <= 1'b1;
            o_fault     <= 1'b1;
            o_load_data <= 32'd0;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: randomized self-checking bench for lsu against a transaction-level model.
module tb_lsu;

  localparam int unsigned TW      = 4;
  localparam int          TO_REQS = (1 << TW) - 1;

  logic        i_clk_n = 1'b0;
  logic        i_rst_n;
  logic        i_valid, i_load, i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_store_data;
  logic        o_busy, o_done, o_fault;
  logic [31:0] o_load_data;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  lsu #(.TIMEOUT_W(TW)) dut (
    .i_clk_n      (i_clk_n),
    .i_rst_n      (i_rst_n),
    .i_valid      (i_valid),
    .i_load       (i_load),
    .i_store      (i_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_store_data (i_store_data),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_load_data  (o_load_data),
    .o_fault      (o_fault),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wstrb  (o_mem_wstrb),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_ack    (i_mem_ack),
    .i_mem_rdata  (i_mem_rdata)
  );

  initial forever #5 i_clk_n = ~i_clk_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---- reference model ----
  function automatic logic m_bad(input logic ld, input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    int   size;
    if (ld) bad = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
    else    bad = (f3 > 3'd2);
    size = 1 << f3[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
    if (!bad && (int'(off) % size) != 0) bad = 1'b1;
`else
    if (size < 0 && off == 2'd0) bad = 1'b1;
`endif
    return bad;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] off,
                                         input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (32'(off) * 8)) & 32'hFF;
    h = (rd >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'h80)   ? b - 32'h100   : b;
      3'd1:    return (h >= 32'h8000) ? h - 32'h10000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'hFF) * 32'h0101_0101;
      3'd1:    return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0:    return 4'(32'd1 << off);
      3'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // ack_dly: REQ cycle (1-based) on which ack is driven; 0 means never
  task automatic run_txn(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [31:0] rd, input int ack_dly);
    logic        bad, exp_fault, got_done;
    logic [31:0] exp_ld, exp_wd;
    logic [3:0]  exp_ws;
    int          exp_req, nreq;
    bad       = m_bad(ld, f3, addr[1:0]);
    exp_fault = bad || (ack_dly == 0);
    exp_req   = bad ? 0 : (ack_dly == 0 ? TO_REQS : ack_dly);
    exp_ld    = (exp_fault || !ld) ? 32'd0 : m_load(f3, addr[1:0], rd);
    exp_wd    = ld ? 32'd0 : m_wdata(f3, sd);
    exp_ws    = ld ? 4'd0  : m_wstrb(f3, addr[1:0]);

    chk("done_idle", 32'(o_done), 32'd0);
    i_valid = 1'b1; i_load = ld; i_store = !ld;
    i_funct3 = f3; i_addr = addr; i_store_data = sd;
    #1 chk("busy_accept", 32'(o_busy), 32'd1);
    @(negedge i_clk_n);
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
    i_addr = $urandom; i_store_data = $urandom; i_funct3 = 3'($urandom);
    nreq = 0; got_done = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (o_done) begin got_done = 1'b1; break; end
      chk("req", 32'(o_mem_req), 32'd1);
      chk("busy_req", 32'(o_busy), 32'd1);
      chk("mem_addr", o_mem_addr, {addr[31:2], 2'b00});
      chk("mem_we", 32'(o_mem_we), 32'(!ld));
      chk("mem_wstrb", 32'(o_mem_wstrb), 32'(exp_ws));
      chk("mem_wdata", o_mem_wdata, exp_wd);
      nreq++;
      i_mem_ack   = (nreq == ack_dly);
      i_mem_rdata = (nreq == ack_dly) ? rd : $urandom;
      @(negedge i_clk_n);
    end
    i_mem_ack = 1'b0;
    chk("done_seen", 32'(got_done), 32'd1);
    chk("req_cycles", 32'(nreq), 32'(exp_req));
    chk("fault", 32'(o_fault), 32'(exp_fault));
    chk("load_data", o_load_data, exp_ld);
    chk("busy_done", 32'(o_busy), 32'd0);
    chk("req_done", 32'(o_mem_req), 32'd0);
    @(negedge i_clk_n);
  endtask

  initial begin
    logic ld;
    i_rst_n = 1'b0; i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
    i_funct3 = 3'd0; i_addr = 32'd0; i_store_data = 32'd0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
    repeat (3) @(negedge i_clk_n);
    chk("rst_req", 32'(o_mem_req), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_fault", 32'(o_fault), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_load_data", o_load_data, 32'd0);
    chk("rst_addr", o_mem_addr, 32'd0);
    chk("rst_wstrb", 32'(o_mem_wstrb), 32'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk_n);

    // Directed cases
    run_txn(1'b0, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0, 1);
    run_txn(1'b1, 3'd0, 32'h0000_2001, 32'h0, 32'h0000_8000, 1);
    run_txn(1'b1, 3'd4, 32'h0000_2001, 32'h0, 32'h0000_8000, 1);
    run_txn(1'b1, 3'd5, 32'h0000_2002, 32'h0, 32'hBEEF_0000, 1);
    run_txn(1'b1, 3'd2, 32'h0000_4000, 32'h0, 32'h1234_5678, 5);
    run_txn(1'b1, 3'd2, 32'h0000_5004, 32'h0, 32'hDEAD_BEEF, 0);
    run_txn(1'b1, 3'd1, 32'h0000_3001, 32'h0, 32'h1234_F00D, 2);
    run_txn(1'b0, 3'd1, 32'h0000_3002, 32'hCAFE_1234, 32'h0, 1);
    run_txn(1'b1, 3'd3, 32'h0000_0000, 32'h0, 32'h0, 1);
    run_txn(1'b0, 3'd4, 32'h0000_0000, 32'h1, 32'h0, 1);

    // Load and store together: nothing accepted
    i_valid = 1'b1; i_load = 1'b1; i_store = 1'b1; i_funct3 = 3'd2;
    #1 chk("both_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk_n);
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0;
    chk("both_req", 32'(o_mem_req), 32'd0);
    chk("both_done", 32'(o_done), 32'd0);

    // Stray ack while idle is ignored
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFF_FFFF;
    @(negedge i_clk_n);
    @(negedge i_clk_n);
    chk("stray_ack_done", 32'(o_done), 32'd0);
    chk("stray_ack_req", 32'(o_mem_req), 32'd0);
    i_mem_ack = 1'b0;

    // Reset in the middle of REQ
    i_valid = 1'b1; i_load = 1'b1; i_funct3 = 3'd2; i_addr = 32'h0000_6000;
    @(negedge i_clk_n);
    i_valid = 1'b0; i_load = 1'b0;
    repeat (2) @(negedge i_clk_n);
    chk("pre_rst_req", 32'(o_mem_req), 32'd1);
    i_rst_n = 1'b0;
    #1 chk("async_rst_req", 32'(o_mem_req), 32'd0);
    chk("async_rst_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk_n);
    i_rst_n = 1'b1;
    @(negedge i_clk_n);
    chk("rst_no_done", 32'(o_done), 32'd0);
    run_txn(1'b0, 3'd2, 32'h0000_7000, 32'h89AB_CDEF, 32'h0, 1);
    run_txn(1'b1, 3'd2, 32'h0000_7000, 32'h0, 32'h89AB_CDEF, 1);

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      int dly;
      ld  = 1'($urandom);
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      run_txn(ld, 3'($urandom), $urandom, $urandom, $urandom, dly);
      if ($urandom_range(0, 3) == 0) @(negedge i_clk_n);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
